// File: rtl/sram_sched_pkg.sv
// Shared widths, FSM state and read-response tag for the SRAM round-robin scheduler.
package sram_sched_pkg;

  localparam int SRAM_ADDR_W    = 12;
  localparam int SRAM_DATA_W    = 16;
  localparam int SCHED_READ_LAT = 2;
  // Wide enough for a requester index with up to 8 requesters.
  localparam int SCHED_ID_W     = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    WR_HOLD = 1'b1
  } sched_state_t;

  typedef struct packed {
    logic                  valid;
    logic [SCHED_ID_W-1:0] id;
  } rsp_tag_t;

  function automatic rsp_tag_t make_tag(input logic valid, input logic [SCHED_ID_W-1:0] id);
    rsp_tag_t t;
    t.valid = valid;
    t.id    = id;
    return t;
  endfunction

endpackage

// File: rtl/sram_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer, wrapping around.
module rr_arbiter
  import sram_sched_pkg::*;
#(
  parameter  int NREQ  = 2,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             enable,
  input  logic             advance,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan requesters starting at the pointer; first valid one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NREQ);
      if (enable && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end else begin
        found = found;
      end
    end
  end

  // Pointer moves just past the winner so it becomes lowest priority next time.
  always_comb begin
    if (grant_idx == IDX_W'(NREQ - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = grant_idx + IDX_W'(1);
    end
  end

  // Pointer register, advanced only on an accepted handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= next_ptr;
    end
  end

endmodule

// File: rtl/sram_rr_scheduler.sv
// Shares one 1RW SRAM wrapper between NREQ requesters with round-robin arbitration,
// write re-timing against the wrapper's write-data register, and fixed-latency read return.
module sram_rr_scheduler
  import sram_sched_pkg::*;
#(
  parameter int ADDR_W   = SRAM_ADDR_W,
  parameter int DATA_W   = SRAM_DATA_W,
  parameter int NREQ     = 2,
  parameter int READ_LAT = SCHED_READ_LAT
) (
  input  logic                   RW0_clk,
  input  logic                   RW0_rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_wmode,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic [ADDR_W-1:0]      sram_RW0_addr,
  output logic [DATA_W-1:0]      sram_RW0_wdata,
  output logic                   sram_RW0_en,
  output logic                   sram_RW0_wmode,
  input  logic [DATA_W-1:0]      sram_RW0_rdata
);

  localparam int IDX_W = $clog2(NREQ);

  sched_state_t     state;
  sched_state_t     state_next;
  logic [NREQ-1:0]  grant;
  logic [IDX_W-1:0] grant_idx;
  logic             arb_enable;
  logic             accept;
  logic             acc_read;
  logic             acc_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [ADDR_W-1:0] pend_addr;
  rsp_tag_t          tag_pipe [0:READ_LAT];

  // Ready is held low during reset so no handshake can complete while the block is cleared.
  assign arb_enable = (state == IDLE) && RW0_rst_n;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .clk       (RW0_clk),
    .rst_n     (RW0_rst_n),
    .req       (req_valid),
    .enable    (arb_enable),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Decode the winning requester's payload and command type.
  always_comb begin
    req_ready = grant;
    accept    = |grant;
    sel_addr  = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
    sel_wdata = req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
    acc_write = accept && req_wmode[grant_idx];
    acc_read  = accept && !req_wmode[grant_idx];
  end

  // FSM state register.
  always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
    if (!RW0_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A write blocks accepts for one cycle while its data sits in the wrapper's register.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (acc_write) begin
          state_next = WR_HOLD;
        end else begin
          state_next = IDLE;
        end
      end
      WR_HOLD: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // SRAM command registers: reads issue next cycle, writes issue from WR_HOLD.
  always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
    if (!RW0_rst_n) begin
      sram_RW0_en    <= 1'b0;
      sram_RW0_wmode <= 1'b0;
      sram_RW0_addr  <= '0;
      sram_RW0_wdata <= '0;
      pend_addr      <= '0;
    end else begin
      sram_RW0_en    <= acc_read || (state == WR_HOLD);
      sram_RW0_wmode <= (state == WR_HOLD);
      if (acc_read) begin
        sram_RW0_addr <= sel_addr;
      end else if (state == WR_HOLD) begin
        sram_RW0_addr <= pend_addr;
      end
      if (acc_write) begin
        sram_RW0_wdata <= sel_wdata;
        pend_addr      <= sel_addr;
      end
    end
  end

  // Read tag pipeline; the last stage lines up with valid RW0_rdata.
  always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
    if (!RW0_rst_n) begin
      for (int i = 0; i <= READ_LAT; i++) begin
        tag_pipe[i] <= make_tag(1'b0, '0);
      end
    end else begin
      tag_pipe[0] <= make_tag(acc_read, SCHED_ID_W'(grant_idx));
      for (int i = 1; i <= READ_LAT; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  // One-hot response strobe decoded from the registered tag.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = tag_pipe[READ_LAT].valid && (tag_pipe[READ_LAT].id == SCHED_ID_W'(i));
    end
  end

  assign rsp_rdata = sram_RW0_rdata;

endmodule

// File: tb/tb_sram_rr_scheduler.sv
// Directed bench for sram_rr_scheduler with a behavioural SRAM wrapper and a cycle-level reference model.
module tb_sram_rr_scheduler;

  localparam int AW   = 12;
  localparam int DW   = 16;
  localparam int NR   = 2;
  localparam int MAXC = 512;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    req_wmode;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic [AW-1:0]    sram_addr;
  logic [DW-1:0]    sram_wdata;
  logic             sram_en;
  logic             sram_wmode;
  logic [DW-1:0]    sram_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_rr_scheduler #(.ADDR_W(AW), .DATA_W(DW), .NREQ(NR), .READ_LAT(2)) dut (
    .RW0_clk        (clk),
    .RW0_rst_n      (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_wmode      (req_wmode),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .sram_RW0_addr  (sram_addr),
    .sram_RW0_wdata (sram_wdata),
    .sram_RW0_en    (sram_en),
    .sram_RW0_wmode (sram_wmode),
    .sram_RW0_rdata (sram_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural SRAM wrapper: registered write data, two-edge read latency.
  logic [DW-1:0] wmem [4096];
  logic [DW-1:0] wd_q, rd1, rdq;
  logic          wrap_init = 1'b0;
  always @(posedge clk) begin
    if (!wrap_init) begin
      for (int i = 0; i < 4096; i++) wmem[i] <= 16'(i) ^ 16'hA5A5;
      wrap_init <= 1'b1;
    end else begin
      if (sram_en && sram_wmode) wmem[sram_addr] <= wd_q;
    end
    wd_q <= sram_wdata;
    if (sram_en && !sram_wmode) rd1 <= wmem[sram_addr];
    rdq <= rd1;
  end
  assign sram_rdata = rdq;

  // Reference model: per-cycle expectations scheduled from each accepted request.
  logic [DW-1:0] m_mem [4096];
  logic          exp_en    [MAXC];
  logic          exp_wmode [MAXC];
  logic [AW-1:0] exp_addr  [MAXC];
  logic [NR-1:0] exp_rsp   [MAXC];
  logic [DW-1:0] exp_rdata [MAXC];
  logic [DW-1:0] exp_wdata [MAXC];
  int            m_ptr, cyc, g, j;
  logic          m_block;
  logic [NR-1:0] eready;
  logic [AW-1:0] a;
  logic [DW-1:0] d;

  initial begin
    for (int i = 0; i < 4096; i++) m_mem[i] = 16'(i) ^ 16'hA5A5;
    for (int i = 0; i < MAXC; i++) begin
      exp_en[i] = 1'b0; exp_wmode[i] = 1'b0; exp_addr[i] = '0;
      exp_rsp[i] = '0; exp_rdata[i] = '0; exp_wdata[i] = '0;
    end
    m_ptr = 0; m_block = 1'b0; cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("cmp_rst_ready", 32'(req_ready), 32'd0);
        check("cmp_rst_en", 32'(sram_en), 32'd0);
        check("cmp_rst_rsp", 32'(rsp_valid), 32'd0);
        check("cmp_rst_wdata", 32'(sram_wdata), 32'd0);
        m_ptr = 0; m_block = 1'b0;
        for (int k = cyc; k < MAXC; k++) begin
          exp_en[k] = 1'b0; exp_rsp[k] = '0; exp_wdata[k] = '0;
        end
      end else begin
        eready = '0; g = -1;
        if (!m_block) begin
          for (int i = 0; i < NR; i++) begin
            j = (m_ptr + i) % NR;
            if (g < 0 && req_valid[j]) g = j;
          end
        end
        if (g >= 0) eready[g] = 1'b1;
        check("cmp_ready", 32'(req_ready), 32'(eready));
        check("cmp_en", 32'(sram_en), 32'(exp_en[cyc]));
        if (exp_en[cyc]) begin
          check("cmp_wmode", 32'(sram_wmode), 32'(exp_wmode[cyc]));
          check("cmp_addr", 32'(sram_addr), 32'(exp_addr[cyc]));
        end
        check("cmp_rsp", 32'(rsp_valid), 32'(exp_rsp[cyc]));
        if (exp_rsp[cyc] != '0) check("cmp_rdata", 32'(rsp_rdata), 32'(exp_rdata[cyc]));
        check("cmp_wdata", 32'(sram_wdata), 32'(exp_wdata[cyc]));
        m_block = 1'b0;
        if (g >= 0 && cyc + 3 < MAXC) begin
          m_ptr = (g + 1) % NR;
          a = req_addr[g*AW +: AW];
          d = req_wdata[g*DW +: DW];
          if (req_wmode[g]) begin
            for (int k = cyc + 1; k < MAXC; k++) exp_wdata[k] = d;
            exp_en[cyc+2] = 1'b1; exp_wmode[cyc+2] = 1'b1; exp_addr[cyc+2] = a;
            m_mem[a] = d;
            m_block = 1'b1;
          end else begin
            exp_en[cyc+1] = 1'b1; exp_wmode[cyc+1] = 1'b0; exp_addr[cyc+1] = a;
            exp_rsp[cyc+3] = NR'(1) << g;
            exp_rdata[cyc+3] = m_mem[a];
          end
        end
      end
      cyc++;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Directed stimulus with hand-computed literal expectations.
  initial begin
    logic got;
    int   idx;
    rst_n = 1'b0; req_valid = '0; req_wmode = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle: nothing requested for 10 cycles.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("lit_idle_ready", 32'(req_ready), 32'd0);
      check("lit_idle_en", 32'(sram_en), 32'd0);
      nxt();
    end

    // Two requesters reading continuously alternate grants.
    req_addr = {12'h020, 12'h010}; req_wmode = 2'b00; req_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("lit_rr_ready", 32'(req_ready), (k < 4) ? ((k % 2 == 0) ? 32'h1 : 32'h2) : 32'h0);
      if (k >= 1 && k <= 4) begin
        check("lit_rr_en", 32'(sram_en), 32'h1);
        check("lit_rr_addr", 32'(sram_addr), (k % 2 == 1) ? 32'h010 : 32'h020);
      end
      if (k >= 3 && k <= 6) begin
        check("lit_rr_rsp", 32'(rsp_valid), (k % 2 == 1) ? 32'h1 : 32'h2);
        check("lit_rr_rdata", 32'(rsp_rdata), (k % 2 == 1) ? 32'hA5B5 : 32'hA585);
      end
      nxt();
      if (k == 3) req_valid = 2'b00;
    end

    // Write 0xBEEF to 0x005, then read it back.
    req_valid = 2'b01; req_wmode = 2'b01; req_addr = {12'h000, 12'h005}; req_wdata = {16'h0000, 16'hBEEF};
    @(negedge clk); check("lit_wr_ready", 32'(req_ready), 32'h1);
    nxt(); req_valid = 2'b00;
    @(negedge clk); check("lit_wr_wdata", 32'(sram_wdata), 32'hBEEF);
    nxt();
    @(negedge clk);
    check("lit_wr_cmd", {30'd0, sram_en, sram_wmode}, 32'h3);
    check("lit_wr_addr", 32'(sram_addr), 32'h005);
    nxt(); req_valid = 2'b01; req_wmode = 2'b00;
    @(negedge clk); check("lit_rd_ready", 32'(req_ready), 32'h1);
    nxt(); req_valid = 2'b00;
    @(negedge clk); check("lit_rd_cmd", {30'd0, sram_en, sram_wmode}, 32'h2);
    nxt();
    @(negedge clk); check("lit_rd_early", 32'(rsp_valid), 32'h0);
    nxt();
    @(negedge clk);
    check("lit_rd_rsp", 32'(rsp_valid), 32'h1);
    check("lit_rd_rdata", 32'(rsp_rdata), 32'hBEEF);
    nxt();

    // r1 writes 0x1234 @0xFFF while r0 reads 0xFFF in the same cycle.
    req_valid = 2'b11; req_wmode = 2'b10; req_addr = {12'hFFF, 12'hFFF}; req_wdata = {16'h1234, 16'h0000};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) check("lit_wr2_ready", 32'(req_ready), 32'h2);
      if (k == 1) begin
        check("lit_wr2_block", 32'(req_ready), 32'h0);
        check("lit_wr2_wdata", 32'(sram_wdata), 32'h1234);
      end
      if (k == 2) begin
        check("lit_wr2_cmd", {30'd0, sram_en, sram_wmode}, 32'h3);
        check("lit_wr2_rdready", 32'(req_ready), 32'h1);
      end
      if (k == 5) begin
        check("lit_wr2_rsp", 32'(rsp_valid), 32'h1);
        check("lit_wr2_rdata", 32'(rsp_rdata), 32'h1234);
      end
      nxt();
      if (k == 0) req_valid = 2'b01;
      if (k == 2) req_valid = 2'b00;
    end

    // Continuous writes from r0: one accept every other cycle.
    idx = 0;
    req_valid = 2'b01; req_wmode = 2'b01; req_addr = {12'h000, 12'h100}; req_wdata = {16'h0000, 16'h1000};
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      got = req_ready[0];
      check("lit_cw_ready", 32'(req_ready), (c % 2 == 0 && c < 8) ? 32'h1 : 32'h0);
      check("lit_cw_en", 32'(sram_en), (c >= 2 && c % 2 == 0) ? 32'h1 : 32'h0);
      if (c >= 2 && c % 2 == 0) check("lit_cw_addr", 32'(sram_addr), 32'(12'h100 + 12'(c/2 - 1)));
      if (c >= 1) check("lit_cw_wdata", 32'(sram_wdata), 32'(16'h1000 + 16'((c - 1) / 2)));
      nxt();
      if (got) begin
        idx++;
        if (idx == 4) begin
          req_valid = 2'b00;
        end else begin
          req_addr[AW-1:0] = 12'h100 + 12'(idx);
          req_wdata[DW-1:0] = 16'h1000 + 16'(idx);
        end
      end
    end

    // Reset during an in-flight read drops it and rewinds the pointer.
    req_valid = 2'b01; req_wmode = 2'b00; req_addr = {12'h000, 12'h005};
    @(negedge clk); check("lit_rst_accept", 32'(req_ready), 32'h1);
    nxt(); req_valid = 2'b00;
    #1 rst_n = 1'b0;
    #1;
    check("lit_rst_en", 32'(sram_en), 32'h0);
    check("lit_rst_rsp", 32'(rsp_valid), 32'h0);
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("lit_rst_norsp", 32'(rsp_valid), 32'h0);
      check("lit_rst_noen", 32'(sram_en), 32'h0);
      nxt();
    end
    req_valid = 2'b11; req_wmode = 2'b00;
    @(negedge clk); check("lit_rst_ptr", 32'(req_ready), 32'h1);
    nxt(); req_valid = 2'b00;
    repeat (6) nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_rr_scheduler.md
Name: sram_rr_scheduler

Overview:
- Shares one single-port `sram_wrapper` instance (1RW, registered write data, registered read data) between NREQ requesters.
- Arbitrates round-robin with a valid/ready request handshake.
- Re-times write commands so they line up with the wrapper's one-cycle write-data register.
- Returns read data to the issuing requester at a fixed latency.
- Sits between client logic (cache/DMA ports) and the SRAM wrapper in the test_sram design.

Parameters:
- ADDR_W, 12, SRAM address width; must match the attached wrapper.
- DATA_W, 16, SRAM data width; must match the attached wrapper.
- NREQ, 2, number of requesters; legal range 2..8.
- READ_LAT, 2, edges from the SRAM sampling the read command to RW0_rdata being valid; fixed by the wrapper.

Ports:
- RW0_clk  in  1  clock; drives this block and the SRAM wrapper.
- RW0_rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; combinational, one-hot or zero.
- req_wmode  in  NREQ  per-requester; 1 = write, 0 = read.
- req_addr  in  NREQ*ADDR_W  per-requester address; requester i in slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NREQ*DATA_W  per-requester write data; requester i in slice [i*DATA_W +: DATA_W].
- rsp_valid  out  NREQ  one-cycle read-response strobe, one-hot.
- rsp_rdata  out  DATA_W  read data; valid only while some rsp_valid bit is set.
- sram_RW0_addr  out  ADDR_W  to wrapper RW0_addr; registered.
- sram_RW0_wdata  out  DATA_W  to wrapper RW0_wdata; registered.
- sram_RW0_en  out  1  to wrapper RW0_en; registered.
- sram_RW0_wmode  out  1  to wrapper RW0_wmode; registered.
- sram_RW0_rdata  in  DATA_W  from wrapper RW0_rdata.

Behaviour:
- Reset (async assert, sync deassert edge use):
  - All sram_* outputs, rsp_valid and req_ready are 0.
  - State is IDLE, the round-robin pointer is 0, and the response shift register is cleared.
  - Reset mid-write or with a read in flight drops that operation: no rsp_valid is emitted and sram_RW0_en stays 0.
- States:
  - IDLE: may accept.
  - WR_HOLD: one cycle after a write was accepted; no accept.
  - Transitions: IDLE -> WR_HOLD on write accept; WR_HOLD -> IDLE unconditionally; a read accept stays in IDLE.
- Arbitration, in IDLE only:
  - Grant the first valid requester at or after the pointer, in ascending order with wrap-around.
  - req_ready[g]=1 for that requester only.
  - The handshake is valid&ready in the same cycle.
  - On accept, the pointer becomes g+1 mod NREQ; with no accept the pointer holds.
  - A requester must hold its valid and payload stable until accepted.
- Read accepted in cycle T:
  - sram_RW0_en=1, wmode=0, addr=req addr in cycle T+1; the wrapper samples at the end of T+1.
  - rsp_valid[g]=1 with rsp_rdata=sram_RW0_rdata (pass-through) in cycle T+1+READ_LAT, i.e. T+3 with the default.
  - Requester id is tracked in a READ_LAT+1 deep valid/id shift register.
  - Back-to-back reads are allowed: one per cycle.
- Write accepted in cycle T:
  - sram_RW0_wdata=data in cycle T+1; the wrapper registers it, so the macro sees it in T+2.
  - sram_RW0_en=1, wmode=1, addr in cycle T+2.
  - Next accept is possible in T+1 (WR_HOLD) is blocked; next accept is in T+2, with its command in T+3.
  - Write throughput: one per 2 cycles.
  - No rsp_valid for writes.
- Cycles with no command: sram_RW0_en=0.
  - sram_RW0_addr holds its last value.
  - sram_RW0_wdata changes only on write accept.
- Ordering:
  - Commands reach the SRAM in accept order.
  - A read accepted after a write to the same address returns the new data.
- Responses have no backpressure; the requester must always sink them.
- At most one rsp_valid bit is set per cycle, because commands are serialized.

Decomposition:
- Package `sram_sched_pkg` holds:
  - SRAM_ADDR_W=12, SRAM_DATA_W=16, SCHED_READ_LAT=2;
  - typedef enum logic {IDLE, WR_HOLD} sched_state_t;
  - typedef struct {valid, id[$clog2(NREQ)]} rsp_tag_t.
- Sub-module `rr_arbiter`, parameterised on NREQ:
  - inputs: request vector, enable, advance;
  - outputs: one-hot grant and its index;
  - contains the pointer register.

Test Plan:
- Single read, requester 0, addr 0x005, after a prior write of 0xBEEF to 0x005 -> req_ready[0] in cycle T; sram_en=1/wmode=0 in T+1; rsp_valid=2'b01, rsp_rdata=0xBEEF in T+3.
- Both requesters hold valid reads continuously (r0 addr 0x010, r1 addr 0x020), pointer at 0 -> grants alternate 0,1,0,1; addresses alternate on consecutive cycles; rsp_valid alternates 01,10 starting 3 cycles after the first accept.
- Write 0x1234 @0xFFF by r1, then read 0xFFF by r0 presented in the same cycle -> write accepted T; no accept T+1; sram_wdata=0x1234 at T+1; write command at T+2; read accepted T+2; rsp_rdata=0x1234 at T+5.
- Continuous writes from r0 -> req_ready[0] high every other cycle; sram_en pulses every other cycle; each command's wdata is the one accepted 2 cycles earlier.
- Reset asserted asynchronously in cycle T+1 after a read accept at T -> sram_en=0 immediately; no rsp_valid after release; pointer back to 0.
- No requests for 10 cycles -> sram_en=0 and req_ready=0 throughout; the pointer is unchanged.
